// File: rtl/pipe_stage_chain_pkg.sv
// Shared helpers for the pipe_stage_chain register pipeline.
package pipe_stage_chain_pkg;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Ready/valid stream bundle for pipe_stage_chain, including flush and occupancy.
interface pipe_stage_chain_if
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int OCC_W = occ_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // Side that drives beats in, consumes beats out and controls flush.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The pipeline itself.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: a valid bit plus a WIDTH-bit payload register.
module pipe_stage_cell #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid bit: reset and flush empty the stage, load copies the upstream valid.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value and the chain shifts by exactly one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_clear_data
      // Payload with clearing: reset and flush zero it, a valid beat loads it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data <= '0;
        end else if (flush) begin
          data <= '0;
        end else if (load && in_valid) begin
          data <= in_data;
        end
      end
    end else begin : g_keep_data
      // Payload without clearing: only a valid beat ever changes it.
      // NOTE: this data register deliberately has no reset; the valid bit alone
      // says whether the contents mean anything, so the flop can stay reset-free.
      always_ff @(posedge clk) begin
        if (!flush && load && in_valid) begin
          data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep stallable, flushable register pipeline with bubble collapsing.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit CLEAR_DATA = 1'b1
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_chain_if.slave bus
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [DEPTH-1:0] stg_vin;
  logic [WIDTH-1:0] stg_din [DEPTH];
  logic             in_rdy;
  logic [OCC_W-1:0] occ;

  // Ready chain from the output back to the input: an empty stage always
  // accepts, which is what lets a stalled output compact the beats behind it.
  always_comb begin
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !valid[i] || rdy[i + 1];
    end
  end

  assign in_rdy = rdy[0] && !bus.flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign stg_vin[i] = bus.in_valid && in_rdy;
        assign stg_din[i] = bus.in_data;
      end else begin : g_body
        assign stg_vin[i] = valid[i - 1];
        assign stg_din[i] = data[i - 1];
      end

      pipe_stage_cell #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .load     (rdy[i]),
        .in_valid (stg_vin[i]),
        .in_data  (stg_din[i]),
        .valid    (valid[i]),
        .data     (data[i])
      );
    end
  endgenerate

  // Occupancy is the population count of the registered valid bits.
  // NOTE: occ gets a default before the loop so no path leaves it unassigned,
  // which keeps this block purely combinational instead of inferring a latch.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid[i]);
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = valid[DEPTH - 1];
  assign bus.out_data  = data[DEPTH - 1];
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=3), with a scoreboard
// queue and two DUTs sharing stimulus: one clears data, one keeps it.
module tb_pipe_stage_chain;
  import pipe_stage_chain_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int OCC_W = occ_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_push    = 0;
  int n_pop     = 0;

  logic [WIDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_c ();
  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_n ();

  assign bus_c.flush     = flush;
  assign bus_c.in_valid  = in_valid;
  assign bus_c.in_data   = in_data;
  assign bus_c.out_ready = out_ready;
  assign bus_n.flush     = flush;
  assign bus_n.in_valid  = in_valid;
  assign bus_n.in_data   = in_data;
  assign bus_n.out_ready = out_ready;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_DATA(1'b1)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_DATA(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  // Scoreboard: record accepted beats and compare delivered beats, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_c.in_valid && bus_c.in_ready) begin
        sb_q.push_back(bus_c.in_data);
        n_push++;
      end
      if (bus_c.out_valid && bus_c.out_ready) begin
        n_asserts++;
        n_pop++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat: got out_data=%h, required no beat", bus_c.out_data);
        end else begin
          logic [WIDTH-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (bus_c.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_out_data: got %h, required %h", bus_c.out_data, exp_d);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present base, base+1, ... advancing only on acceptance, within max_cycles.
  task automatic drive_beats(input int n, input logic [WIDTH-1:0] base,
                             input int max_cycles, output int acc_cnt);
    int   k;
    int   budget;
    logic acc;
    k = 0;
    budget = 0;
    while (k < n && budget < max_cycles) begin
      in_valid = 1'b1;
      in_data  = base + WIDTH'(k);
      @(negedge clk);
      acc = bus_c.in_valid && bus_c.in_ready;
      tick();
      if (acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    acc_cnt  = k;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic check_sb_empty(input string name);
    n_asserts++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb_left: got %0d beats outstanding, required 0", name, sb_q.size());
    end
  endtask

  // Send one beat into an empty chain and count cycles until it reaches the output.
  task automatic send_and_time(input string name, input logic [WIDTH-1:0] value);
    int cycles;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = value;
    tick();
    in_valid = 1'b0;
    cycles   = 1;
    while (!bus_c.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    n_asserts++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cycles, DEPTH);
    end
    n_asserts++;
    if (bus_c.out_data !== value) begin
      n_fail++;
      $display("FAIL %s_data: got %h, required %h", name, bus_c.out_data, value);
    end
  endtask

  task automatic test_reset();
    int acc;
    #1;
    n_asserts++;
    if (bus_c.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus_c.out_valid);
    end
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(0)) begin
      n_fail++; $display("FAIL reset_occupancy: got %0d, required 0", bus_c.occupancy);
    end
    n_asserts++;
    if (bus_c.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus_c.in_ready);
    end
    n_asserts++;
    if (bus_c.out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %h, required 0", bus_c.out_data);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // Load two beats under stall, then pulse reset between clock edges.
    out_ready = 1'b0;
    drive_beats(2, 32'h0BAD_0000, 6, acc);
    #2 rst = 1'b1;
    #1;
    n_asserts++;
    if (bus_c.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_out_valid: got %b, required 0", bus_c.out_valid);
    end
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(0)) begin
      n_fail++; $display("FAIL async_reset_occupancy: got %0d, required 0", bus_c.occupancy);
    end
    sb_q.delete();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    send_and_time("latency", 32'hA5A5_0001);
    drain();
    check_sb_empty("latency");
  endtask

  task automatic test_streaming();
    int pops0;
    int exp_occ;
    pops0     = n_pop;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000_0000 + WIDTH'(i);
      tick();
      exp_occ = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      n_asserts++;
      if (bus_c.occupancy !== OCC_W'(exp_occ)) begin
        n_fail++;
        $display("FAIL stream_occupancy[%0d]: got %0d, required %0d", i, bus_c.occupancy, exp_occ);
      end
    end
    drain();
    n_asserts++;
    if (n_pop - pops0 != 10) begin
      n_fail++; $display("FAIL stream_count: got %0d beats, required 10", n_pop - pops0);
    end
    check_sb_empty("stream");
  endtask

  task automatic test_backpressure();
    int   push0;
    int   pop0;
    int   k;
    int   budget;
    logic acc;
    push0     = n_push;
    pop0      = n_pop;
    out_ready = 1'b0;
    k         = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h2000_0000 + WIDTH'(k);
      @(negedge clk);
      acc = bus_c.in_valid && bus_c.in_ready;
      tick();
      if (acc) k++;
    end
    in_data = 32'h2000_0000 + WIDTH'(k);
    n_asserts++;
    if (n_push - push0 != DEPTH) begin
      n_fail++; $display("FAIL bp_accepted: got %0d, required %0d", n_push - push0, DEPTH);
    end
    n_asserts++;
    if (bus_c.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_low: got %b, required 0", bus_c.in_ready);
    end
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(DEPTH)) begin
      n_fail++; $display("FAIL bp_occupancy: got %0d, required %0d", bus_c.occupancy, DEPTH);
    end
    // Release the stall: in_ready must follow out_ready combinationally.
    out_ready = 1'b1;
    #1;
    n_asserts++;
    if (bus_c.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_in_ready_release: got %b, required 1", bus_c.in_ready);
    end
    @(negedge clk);
    acc = bus_c.in_valid && bus_c.in_ready;
    tick();
    if (acc) k++;
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(DEPTH)) begin
      n_fail++; $display("FAIL bp_full_passthru_occ: got %0d, required %0d", bus_c.occupancy, DEPTH);
    end
    budget = 0;
    while (k < 8 && budget < 20) begin
      in_valid = 1'b1;
      in_data  = 32'h2000_0000 + WIDTH'(k);
      @(negedge clk);
      acc = bus_c.in_valid && bus_c.in_ready;
      tick();
      if (acc) k++;
      budget++;
    end
    drain();
    n_asserts++;
    if ((n_push - push0 != 8) || (n_pop - pop0 != 8)) begin
      n_fail++;
      $display("FAIL bp_conservation: got %0d in / %0d out, required 8 / 8", n_push - push0, n_pop - pop0);
    end
    check_sb_empty("bp");
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3000_00AA;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h3000_00BB;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(2)) begin
      n_fail++; $display("FAIL bubble_occupancy: got %0d, required 2", bus_c.occupancy);
    end
    n_asserts++;
    if (bus_c.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bubble_in_ready: got %b, required 1", bus_c.in_ready);
    end
    n_asserts++;
    if (bus_c.out_valid !== 1'b1 || bus_c.out_data !== 32'h3000_00AA) begin
      n_fail++;
      $display("FAIL bubble_head: got valid=%b data=%h, required valid=1 data=300000aa",
               bus_c.out_valid, bus_c.out_data);
    end
    drain();
    check_sb_empty("bubble");
  endtask

  task automatic test_flush();
    int acc;
    int pop0;
    out_ready = 1'b0;
    drive_beats(3, 32'h4000_0000, 8, acc);
    pop0      = n_pop;
    in_valid  = 1'b1;
    in_data   = 32'h4000_DEAD;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_asserts++;
    if (bus_c.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b, required 0", bus_c.in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(0) || bus_c.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got occ=%0d valid=%b, required occ=0 valid=0",
               bus_c.occupancy, bus_c.out_valid);
    end
    n_asserts++;
    if (bus_c.out_data !== '0) begin
      n_fail++; $display("FAIL flush_clear_data: got %h, required 0", bus_c.out_data);
    end
    n_asserts++;
    if (bus_n.out_data !== 32'h4000_0000) begin
      n_fail++; $display("FAIL flush_keep_data: got %h, required 40000000", bus_n.out_data);
    end
    n_asserts++;
    if (n_pop - pop0 != 1 || sb_q.size() != 2) begin
      n_fail++;
      $display("FAIL flush_delivery: got %0d delivered / %0d killed, required 1 / 2",
               n_pop - pop0, sb_q.size());
    end
    sb_q.delete();
    // The dropped input beat must never appear; a fresh beat must pass cleanly.
    send_and_time("post_flush", 32'h4000_0077);
    drain();
    check_sb_empty("flush");
  endtask

  task automatic test_precedence();
    int acc;
    out_ready = 1'b0;
    drive_beats(5, 32'h5000_0000, 6, acc);
    in_valid = 1'b1;
    in_data  = 32'h5000_0099;
    #2;
    rst   = 1'b1;
    flush = 1'b1;
    #1;
    n_asserts++;
    if (bus_c.occupancy !== OCC_W'(0) || bus_c.out_valid !== 1'b0 || bus_c.out_data !== '0) begin
      n_fail++;
      $display("FAIL prec_async_clear: got occ=%0d valid=%b data=%h, required 0/0/0",
               bus_c.occupancy, bus_c.out_valid, bus_c.out_data);
    end
    sb_q.delete();
    in_valid = 1'b0;
    repeat (2) tick();
    rst   = 1'b0;
    flush = 1'b0;
    send_and_time("prec_after_rst", 32'h5000_0123);
    drain();
    check_sb_empty("prec");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_precedence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
